// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction-cache line refill path.
package icache_pkg;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned BEATS      = LINE_BYTES * 8 / WORD_W;
  localparam int unsigned BEAT_W     = $clog2(BEATS);

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } fill_state_e;

endpackage

// File: rtl/icache_line_buf.sv
// One cache line held as BEATS words: single write port, combinational read port.
module icache_line_buf
  import icache_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BEAT_W-1:0] widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BEAT_W-1:0] ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [BEATS];

  // Contents are only meaningful after a complete fill, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/icache_line_fill.sv
// AXI4 read master that refills one icache line with a single INCR burst and
// exposes the collected line by word index while done_o is high.
//
// state | meaning
// IDLE  | waiting for a refill request
// ADDR  | AR channel presented, waiting for arready
// DATA  | collecting R beats into the line buffer
// DONE  | line complete and readable, waiting for release
module icache_line_fill
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned AXI_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [8:0]        fifo_idx_i,
  input  logic              fifo_done_i,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [ID_W-1:0]   arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid
);

  localparam int unsigned OFS_W = $clog2(LINE_BYTES);

  fill_state_e       state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              err_q, err_d;
  logic              fdone_q, fdone_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;

  logic buf_we;
  logic r_hs;
  logic last_beat;
  logic fdone_rise;
  logic unused_addr_bits;

  assign r_hs       = rvalid && rready_q && (rid == ID_W'(AXI_ID));
  assign last_beat  = (beat_cnt_q == BEAT_W'(BEATS - 1));
  assign fdone_rise = fifo_done_i && !fdone_q;
  assign fdone_d    = fifo_done_i;

  always_comb begin
    state_d    = state_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    err_d      = err_q;
    beat_cnt_d = beat_cnt_q;
    araddr_d   = araddr_q;
    buf_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          araddr_d   = {req_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
          arvalid_d  = 1'b1;
          err_d      = 1'b0;
          beat_cnt_d = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          buf_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (rresp != RESP_OKAY) err_d = 1'b1;
          // The beat counter decides completion; a misplaced rlast only flags.
          if (rlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            rready_d = 1'b0;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (!req_i || fdone_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      err_q      <= 1'b0;
      fdone_q    <= 1'b0;
      beat_cnt_q <= '0;
      araddr_q   <= '0;
    end else begin
      state_q    <= state_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      err_q      <= err_d;
      fdone_q    <= fdone_d;
      beat_cnt_q <= beat_cnt_d;
      araddr_q   <= araddr_d;
    end
  end

  icache_line_buf #(.DATA_W(DATA_W)) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .widx  (beat_cnt_q),
    .wdata (rdata),
    .ridx  (fifo_idx_i[8:6]),
    .rdata (data_o)
  );

  assign unused_addr_bits = ^{req_addr_i[OFS_W-1:0], fifo_idx_i[5:0]};

  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign araddr  = araddr_q;
  assign arlen   = 8'(BEATS - 1);
  assign arsize  = SIZE_8B;
  assign arburst = BURST_INCR;
  assign arid    = ID_W'(AXI_ID);

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: an AXI read slave model feeds beats,
// expected words are queued when driven and compared when read out of DONE.
module tb_icache_line_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [63:0] req_addr_i;
  logic [8:0]  fifo_idx_i;
  logic        fifo_done_i;
  logic        done_o;
  logic [63:0] data_o;
  logic        err_o;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_cmp = 0;
  int n_mis = 0;
  logic [63:0] sb_q [$];

  always #5 clk = ~clk;

  icache_line_fill dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .req_addr_i (req_addr_i),
    .fifo_idx_i (fifo_idx_i),
    .fifo_done_i(fifo_done_i),
    .done_o     (done_o),
    .data_o     (data_o),
    .err_o      (err_o),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arid       (arid),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rid        (rid)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one refill. Negative beat indices disable the corresponding fault.
  task automatic do_fill(input logic [63:0] addr, input int ar_wait, input bit gaps,
                         input bit fixed_words, input int foreign_at, input int bad_resp_at,
                         input int bad_last_at, input int rst_at, input int drop_req_at,
                         input bit exp_err, output int lat);
    logic [63:0] exp_addr;
    logic [63:0] word;
    int k;
    int slot;
    exp_addr = {addr[63:6], 6'b0};
    lat = 0;
    req_i = 1'b1;
    req_addr_i = addr;
    tick(); lat++;
    check_eq("arvalid_on", 64'(arvalid), 64'd1);
    check_eq("araddr", araddr, exp_addr);
    check_eq("err_clr", 64'(err_o), 64'd0);
    check_eq("arlen", 64'(arlen), 64'd7);
    check_eq("arsize", 64'(arsize), 64'd3);
    check_eq("arburst", 64'(arburst), 64'd1);
    check_eq("arid", 64'(arid), 64'd0);
    for (int i = 0; i < ar_wait; i++) begin
      arready = 1'b0;
      check_eq("rready_pre_ar", 64'(rready), 64'd0);
      check_eq("arvalid_hold", 64'(arvalid), 64'd1);
      check_eq("araddr_hold", araddr, exp_addr);
      tick(); lat++;
    end
    arready = 1'b1;
    tick(); lat++;
    arready = 1'b0;
    check_eq("arvalid_off", 64'(arvalid), 64'd0);
    k = 0;
    slot = 0;
    while (k < 8 && slot < 64) begin
      rvalid = 1'b0; rid = 4'd0; rresp = 2'b00; rlast = 1'b0;
      rdata = {$urandom, $urandom};
      if (!(gaps && (slot % 2 == 1))) begin
        rvalid = 1'b1;
        if (slot == foreign_at) begin
          rid = 4'd1;
        end else begin
          word = fixed_words ? 64'h11 * 64'(k + 1) : {$urandom, $urandom};
          rdata = word;
          rresp = (k == bad_resp_at) ? 2'b10 : 2'b00;
          rlast = (k == 7) || (k == bad_last_at);
          if (k == rst_at) rst = 1'b1;
          else sb_q.push_back(word);
          k++;
          if (k == drop_req_at) req_i = 1'b0;
        end
      end
      check_eq("rready_data", 64'(rready), 64'd1);
      tick(); lat++;
      slot++;
      if (rst) begin
        rst = 1'b0; rvalid = 1'b0; req_i = 1'b0;
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_rready", 64'(rready), 64'd0);
        check_eq("rst_arvalid", 64'(arvalid), 64'd0);
        sb_q.delete();
        return;
      end
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    if (k < 8) check_eq("beat_timeout", 64'(k), 64'd8);
    check_eq("done_on", 64'(done_o), 64'd1);
    check_eq("err", 64'(err_o), 64'(exp_err));
    for (int i = 0; i < 8; i++) begin
      fifo_idx_i = {3'(i), 6'($urandom)};
      #1;
      if (sb_q.size() == 0) check_eq("sb_empty", 64'd0, 64'd1);
      else check_eq("data", data_o, sb_q.pop_front());
    end
  endtask

  int lat;

  initial begin
    rst = 1'b1; req_i = 1'b0; req_addr_i = '0; fifo_idx_i = '0; fifo_done_i = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'd0;
    tick(); tick(); tick();
    check_eq("rst_arvalid0", 64'(arvalid), 64'd0);
    check_eq("rst_rready0", 64'(rready), 64'd0);
    check_eq("rst_done0", 64'(done_o), 64'd0);
    check_eq("rst_err0", 64'(err_o), 64'd0);
    check_eq("rst_araddr0", araddr, 64'd0);
    rst = 1'b0;
    tick();

    // Back-to-back beats with a one-cycle AR handshake: minimum latency.
    do_fill(64'h8000_1234, 0, 1'b0, 1'b1, -1, -1, -1, -1, -1, 1'b0, lat);
    check_eq("latency", 64'(lat), 64'd10);
    req_i = 1'b0; tick();
    check_eq("done_exit_req", 64'(done_o), 64'd0);

    do_fill(64'h0000_0040_0000_07ff, 5, 1'b0, 1'b0, -1, -1, -1, -1, -1, 1'b0, lat);
    req_i = 1'b0; tick();
    check_eq("done_exit_req2", 64'(done_o), 64'd0);

    // Gapped R channel with one beat for a different ID.
    do_fill(64'h1234_5678_9abc_def0, 1, 1'b1, 1'b0, 4, -1, -1, -1, -1, 1'b0, lat);
    req_i = 1'b0; tick();
    check_eq("done_exit_req3", 64'(done_o), 64'd0);

    // SLVERR on beat 3, released by a fifo_done_i rise with req_i still high.
    do_fill(64'hffff_ffff_ffff_ffc1, 0, 1'b0, 1'b0, -1, 3, -1, -1, -1, 1'b1, lat);
    fifo_done_i = 1'b1; tick();
    check_eq("done_exit_fdone", 64'(done_o), 64'd0);
    check_eq("err_sticky_idle", 64'(err_o), 64'd1);

    // rlast early on beat 5; new request clears the previous error.
    do_fill(64'h0000_0000_0000_0080, 2, 1'b0, 1'b0, -1, -1, 5, -1, -1, 1'b1, lat);
    fifo_done_i = 1'b0;
    req_i = 1'b0; tick();
    check_eq("done_exit_req5", 64'(done_o), 64'd0);

    // Reset during beat 4, then a clean fill.
    do_fill(64'h0000_0000_dead_bee0, 0, 1'b0, 1'b0, -1, -1, -1, 4, -1, 1'b0, lat);
    tick();
    check_eq("post_rst_idle", 64'(arvalid), 64'd0);
    do_fill(64'h0000_0000_cafe_0100, 0, 1'b0, 1'b0, -1, -1, -1, -1, -1, 1'b0, lat);
    req_i = 1'b0; tick();
    check_eq("done_exit_req7", 64'(done_o), 64'd0);

    // req_i dropped with the final beat, then mid-burst: pass through DONE for one cycle.
    do_fill(64'h0000_0000_0000_1000, 0, 1'b0, 1'b0, -1, -1, -1, -1, 8, 1'b0, lat);
    tick();
    check_eq("done_one_cycle", 64'(done_o), 64'd0);
    do_fill(64'h0000_0000_0000_2000, 0, 1'b1, 1'b0, -1, -1, -1, -1, 3, 1'b0, lat);
    tick();
    check_eq("done_one_cycle2", 64'(done_o), 64'd0);
    tick();
    check_eq("stay_idle", 64'(arvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
